// File: rtl/hazard_scheduler.sv
// Pipeline sequencing for a four-stage IF/ID/EX/WB core: RAW hazard stalls,
// redirect flushes, register-file write gating and saturating bring-up counters.
module hazard_scheduler #(
   parameter int WB_BYPASS = 1,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd_addr,
   input  logic             id_writeback_en,
   input  logic             redirect,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_clear,
   output logic             id_ex_valid,
   output logic             reg_write_en,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] retire_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Without write-through, a WB-stage producer is still invisible to ID reads.
   localparam bit WB_CHECK = (WB_BYPASS == 0);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic       ex_valid_reg;
   logic       ex_we_reg;
   logic [4:0] ex_rd_reg;
   logic       wb_valid_reg;
   logic       wb_we_reg;
   logic [4:0] wb_rd_reg;
   state_t     state_reg;
   state_t     state_next;

   logic [1:0][4:0] src_addr;
   logic [1:0]      src_used;
   logic [1:0]      src_match;
   logic            haz;

   assign src_addr = {id_rs2_addr, id_rs1_addr};
   assign src_used = {id_rs2_used, id_rs1_used};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_match[gi] = src_used[gi] && (src_addr[gi] != 5'd0) &&
            ((ex_valid_reg && ex_we_reg && (ex_rd_reg == src_addr[gi])) ||
             (WB_CHECK && wb_valid_reg && wb_we_reg && (wb_rd_reg == src_addr[gi])));
      end
   endgenerate

   assign haz = id_valid && (|src_match);

   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_clear = 1'b0;
      id_ex_valid = id_valid;
      state_next  = ST_RUN;
      if (redirect) begin
         if_id_clear = 1'b1;
         id_ex_valid = 1'b0;
         state_next  = ST_FLUSH;
      end else if (haz) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_valid = 1'b0;
         state_next  = ST_STALL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // EX and WB always advance; a stall only turns the ID/EX entry into a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_reg <= 1'b0;
         ex_we_reg    <= 1'b0;
         ex_rd_reg    <= 5'd0;
         wb_valid_reg <= 1'b0;
         wb_we_reg    <= 1'b0;
         wb_rd_reg    <= 5'd0;
      end else begin
         ex_valid_reg <= id_ex_valid;
         ex_we_reg    <= id_writeback_en && id_ex_valid;
         ex_rd_reg    <= id_rd_addr;
         wb_valid_reg <= ex_valid_reg;
         wb_we_reg    <= ex_we_reg;
         wb_rd_reg    <= ex_rd_reg;
      end
   end

   assign reg_write_en = wb_valid_reg && wb_we_reg && (wb_rd_reg != 5'd0);
   assign state        = state_reg;

   logic [2:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_value [3];

   assign cnt_inc = {wb_valid_reg, haz && !redirect, 1'b1};

   generate
      for (gi = 0; gi < 3; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign cnt_value[gi] = cnt_reg;
      end
   endgenerate

   assign cycle_count  = cnt_value[0];
   assign stall_count  = cnt_value[1];
   assign retire_count = cnt_value[2];

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: write-through, no-write-through and
// 4-bit-counter instances share one stimulus stream.
module tb_hazard_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] id_rd_addr;
   logic       id_writeback_en;
   logic       redirect;

   // index 0: WB_BYPASS=1, 1: WB_BYPASS=0, 2: WB_BYPASS=1 with CNT_W=4
   logic [2:0] pc_en;
   logic [2:0] if_id_en;
   logic [2:0] if_id_clear;
   logic [2:0] id_ex_valid;
   logic [2:0] reg_write_en;
   logic [1:0] state_o [3];
   logic [31:0] cyc_b, stl_b, ret_b;
   logic [31:0] cyc_n, stl_n, ret_n;
   logic [3:0]  cyc_s, stl_s, ret_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_scheduler #(.WB_BYPASS(1), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_addr(id_rd_addr), .id_writeback_en(id_writeback_en), .redirect(redirect),
      .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_clear(if_id_clear[0]),
      .id_ex_valid(id_ex_valid[0]), .reg_write_en(reg_write_en[0]), .state(state_o[0]),
      .cycle_count(cyc_b), .stall_count(stl_b), .retire_count(ret_b)
   );

   hazard_scheduler #(.WB_BYPASS(0), .CNT_W(32)) dut_n (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_addr(id_rd_addr), .id_writeback_en(id_writeback_en), .redirect(redirect),
      .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_clear(if_id_clear[1]),
      .id_ex_valid(id_ex_valid[1]), .reg_write_en(reg_write_en[1]), .state(state_o[1]),
      .cycle_count(cyc_n), .stall_count(stl_n), .retire_count(ret_n)
   );

   hazard_scheduler #(.WB_BYPASS(1), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_addr(id_rd_addr), .id_writeback_en(id_writeback_en), .redirect(redirect),
      .pc_en(pc_en[2]), .if_id_en(if_id_en[2]), .if_id_clear(if_id_clear[2]),
      .id_ex_valid(id_ex_valid[2]), .reg_write_en(reg_write_en[2]), .state(state_o[2]),
      .cycle_count(cyc_s), .stall_count(stl_s), .retire_count(ret_s)
   );

   // exp = {pc_en, if_id_en, if_id_clear, id_ex_valid, reg_write_en}
   typedef struct {
      logic       vld;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       we;
      logic       redir;
      logic [4:0] exp;
      logic [1:0] exp_state;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic we, input logic redir, input logic [4:0] exp,
                               input logic [1:0] st);
      vec_t v;
      v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.rd = rd; v.we = we; v.redir = redir; v.exp = exp; v.exp_state = st;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic redir);
      id_valid = vld; id_rs1_addr = rs1; id_rs2_addr = rs2;
      id_rs1_used = u1; id_rs2_used = u2; id_rd_addr = rd;
      id_writeback_en = we; redirect = redir;
   endtask

   // Called at a negedge; returns at a negedge with rst released.
   task automatic do_reset();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi, input int sel);
      for (int i = lo; i <= hi; i++) begin
         drive(vecs[i].vld, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
               vecs[i].rd, vecs[i].we, vecs[i].redir);
         #1;
         $display("vec %0d dut %0d: outs=%b state=%0d", i, sel,
                  {pc_en[sel], if_id_en[sel], if_id_clear[sel], id_ex_valid[sel], reg_write_en[sel]},
                  state_o[sel]);
         check($sformatf("vec%0d_outs", i),
               {27'd0, pc_en[sel], if_id_en[sel], if_id_clear[sel], id_ex_valid[sel], reg_write_en[sel]},
               {27'd0, vecs[i].exp});
         check($sformatf("vec%0d_state", i), {30'd0, state_o[sel]}, {30'd0, vecs[i].exp_state});
         @(negedge clk);
      end
   endtask

   initial begin
      // Back-to-back RAW, write-through (dut 0)
      vecs[0]  = mk(1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 5'b11010, 2'd0);
      vecs[1]  = mk(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 5'b00000, 2'd0);
      vecs[2]  = mk(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 5'b11011, 2'd1);
      vecs[3]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11000, 2'd0);
      vecs[4]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11001, 2'd0);
      vecs[5]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11000, 2'd0);
      // Back-to-back RAW, no write-through (dut 1)
      vecs[6]  = mk(1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 5'b11010, 2'd0);
      vecs[7]  = mk(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 5'b00000, 2'd0);
      vecs[8]  = mk(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 5'b00001, 2'd1);
      vecs[9]  = mk(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 5'b11010, 2'd1);
      vecs[10] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11000, 2'd0);
      vecs[11] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11001, 2'd0);
      vecs[12] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11000, 2'd0);
      // x0, unused rs2, rs2 hazard, non-writing producer, invalid ID (dut 0)
      vecs[13] = mk(1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 5'b11010, 2'd0);
      vecs[14] = mk(1, 5'd0, 5'd5, 1, 0, 5'd0, 1, 0, 5'b11010, 2'd0);
      vecs[15] = mk(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 5'b11011, 2'd0);
      vecs[16] = mk(1, 5'd1, 5'd7, 1, 1, 5'd8, 0, 0, 5'b00000, 2'd0);
      vecs[17] = mk(1, 5'd1, 5'd7, 1, 1, 5'd8, 0, 0, 5'b11011, 2'd1);
      vecs[18] = mk(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 5'b11010, 2'd0);
      vecs[19] = mk(0, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 5'b11000, 2'd0);
      // Redirect coinciding with a hazard (dut 0)
      vecs[20] = mk(1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 5'b11010, 2'd0);
      vecs[21] = mk(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 1, 5'b11100, 2'd0);
      vecs[22] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11001, 2'd2);
      vecs[23] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11000, 2'd0);

      // Reset values while rst is held
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_outs_d%0d", d),
               {27'd0, pc_en[d], if_id_en[d], if_id_clear[d], id_ex_valid[d], reg_write_en[d]},
               32'b11000);
         check($sformatf("rst_state_d%0d", d), {30'd0, state_o[d]}, 32'd0);
      end
      @(negedge clk);
      check("rst_cycle_held", cyc_b, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("reset idle: cycle=%0d retire=%0d", cyc_b, ret_b);
      check("idle_cycle_b", cyc_b, 32'd3);
      check("idle_cycle_s", {28'd0, cyc_s}, 32'd3);
      check("idle_retire_b", ret_b, 32'd0);
      check("idle_stall_b", stl_b, 32'd0);

      do_reset();
      run_vecs(0, 5, 0);
      check("bypass_stall", stl_b, 32'd1);
      check("bypass_retire", ret_b, 32'd2);
      check("bypass_cycle", cyc_b, 32'd6);

      do_reset();
      run_vecs(6, 12, 1);
      check("nobypass_stall", stl_n, 32'd2);
      check("nobypass_retire", ret_n, 32'd2);

      do_reset();
      run_vecs(13, 19, 0);
      check("mixed_stall", stl_b, 32'd1);

      do_reset();
      run_vecs(20, 23, 0);
      check("redirect_stall", stl_b, 32'd0);
      check("redirect_stall_n", stl_n, 32'd0);

      // Saturation: 20 cycles of independent instructions
      do_reset();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      $display("saturation: cyc_s=%0d ret_s=%0d cyc_b=%0d ret_b=%0d", cyc_s, ret_s, cyc_b, ret_b);
      check("sat_cycle_s", {28'd0, cyc_s}, 32'd15);
      check("sat_retire_s", {28'd0, ret_s}, 32'd15);
      check("sat_stall_s", {28'd0, stl_s}, 32'd0);
      check("sat_cycle_b", cyc_b, 32'd20);
      check("sat_retire_b", ret_b, 32'd18);

      // Dependent instruction stalls, then reset lands mid-stall
      drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
      #1;
      check("dep_pc_en_s", {31'd0, pc_en[2]}, 32'd0);
      @(negedge clk);
      check("dep_state_b", {30'd0, state_o[0]}, 32'd1);
      check("dep_stall_b", stl_b, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      $display("async reset: cyc_s=%0d ret_s=%0d stl_b=%0d pc_en_b=%0d", cyc_s, ret_s, stl_b, pc_en[0]);
      check("arst_cycle_s", {28'd0, cyc_s}, 32'd0);
      check("arst_retire_s", {28'd0, ret_s}, 32'd0);
      check("arst_stall_b", stl_b, 32'd0);
      check("arst_state_b", {30'd0, state_o[0]}, 32'd0);
      check("arst_pc_en_b", {31'd0, pc_en[0]}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_idex_b", {31'd0, id_ex_valid[0]}, 32'd1);
      check("post_rst_idex_n", {31'd0, id_ex_valid[1]}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
